// File: rtl/rf_stream_selector.sv
// rf_stream_selector
//   Streaming receptive-field extractor for the 1-D conv datapath. A frame of
//   W samples (C channels per beat) is framed by P zero samples on each side,
//   an F-sample window slides over the padded frame with stride S, and each
//   window is offered to the CU array over a valid/ready handshake. Only F
//   samples of history are held; the shift register is the output window.
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      one-cycle pulse, begins a frame when idle
//   in_data    input sample, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   in_valid   in_data valid
//   in_ready   sample accepted this cycle (combinational)
//   out_window window, sample j / channel c at [(j*C+c)*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  out_window/out_index/out_last valid
//   out_ready  consumer accepts window
//   out_index  window number 0..N-1
//   out_last   high with window N-1
//   busy       frame in progress
//   done       one-cycle pulse at end of frame
module rf_stream_selector #(
  parameter int DATA_WIDTH = 16,
  parameter int C          = 1,
  parameter int W          = 1024,
  parameter int P          = 28,
  parameter int F          = 64,
  parameter int S          = 8,
  localparam int L         = W + 2 * P,
  localparam int N         = (L - F) / S + 1,
  localparam int IW        = $clog2(N + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [C*DATA_WIDTH-1:0]   in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [0:F*C*DATA_WIDTH-1] out_window,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IW-1:0]             out_index,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);

  localparam int SW  = C * DATA_WIDTH;
  localparam int FW  = F * SW;
  localparam int PW  = $clog2(L + 1);
  localparam int PHW = $clog2(((F > S) ? F : S) + 1);

  localparam logic [PW-1:0]  POS_END       = PW'(L);
  localparam logic [PW-1:0]  POS_LAST      = PW'(L - 1);
  localparam logic [PW-1:0]  POS_HEAD_LAST = PW'((P > 0) ? (P - 1) : 0);
  localparam logic [PW-1:0]  POS_BODY_LAST = PW'(P + W - 1);
  localparam logic [PHW-1:0] PH_FIRST      = PHW'(F - 1);
  localparam logic [PHW-1:0] PH_STRIDE     = PHW'(S - 1);
  localparam logic [IW-1:0]  WIN_N         = IW'(N);
  localparam logic [IW-1:0]  WIN_LAST      = IW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2,
    ST_TAIL = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [0:FW-1]     r_window;
  logic [0:FW-1]     w_window_nxt;
  logic [0:SW-1]     w_sample;
  logic [PW-1:0]     r_pos;        // number of padded positions shifted so far
  logic [PHW-1:0]    r_phase;      // shifts left until the next window completes
  logic [IW-1:0]     r_win_cnt;    // windows issued so far
  logic [IW-1:0]     r_index;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_last_acc;   // window N-1 already handed over
  logic              r_done;
  logic              w_adv;
  logic              w_shift;
  logic              w_zero;
  logic              w_complete;
  logic              w_accept;
  logic              w_all_in;
  logic              w_last_taken;
  logic              w_done;
  logic              w_start_ok;

  assign out_window = r_window;
  assign out_valid  = r_out_valid;
  assign out_index  = r_index;
  assign out_last   = r_out_last;
  assign done       = r_done;
  assign busy       = (r_state != ST_IDLE);

  // Shift gating: the window may only move when the current one is absent or being taken
  always_comb begin
    w_adv   = !r_out_valid || out_ready;
    w_shift = 1'b0;
    w_zero  = 1'b1;
    case (r_state)
      ST_HEAD: w_shift = w_adv;
      ST_BODY: begin
        w_shift = w_adv && in_valid;
        w_zero  = 1'b0;
      end
      // With P=0 the frame reaches TAIL already fully shifted, so nothing moves there
      ST_TAIL: w_shift = w_adv && (r_pos != POS_END);
      default: w_shift = 1'b0;
    endcase
  end

  assign in_ready     = (r_state == ST_BODY) && w_adv;
  assign w_accept     = r_out_valid && out_ready;
  assign w_complete   = w_shift && (r_phase == {PHW{1'b0}}) && (r_win_cnt != WIN_N);
  assign w_all_in     = (r_pos == POS_END) || (w_shift && (r_pos == POS_LAST));
  assign w_last_taken = r_last_acc || (w_accept && r_out_last);
  assign w_done       = (r_state != ST_IDLE) && w_all_in && w_last_taken;
  // A start coinciding with the done pulse belongs to the frame just closed
  assign w_start_ok   = start && !r_done;

  // Next window contents: drop the oldest sample, append zero or the input beat
  always_comb begin
    w_sample = '0;
    for (int c = 0; c < C; c++) begin
      w_sample[c*DATA_WIDTH +: DATA_WIDTH] = in_data[c*DATA_WIDTH +: DATA_WIDTH];
    end
    w_window_nxt = r_window;
    for (int j = 0; j < F - 1; j++) begin
      w_window_nxt[j*SW +: SW] = r_window[(j+1)*SW +: SW];
    end
    if (w_zero) begin
      w_window_nxt[(F-1)*SW +: SW] = '0;
    end else begin
      w_window_nxt[(F-1)*SW +: SW] = w_sample;
    end
  end

  // Next-state decode for the frame sequencer
  always_comb begin
    w_state_nxt = r_state;
    if (w_done) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            w_state_nxt = (P == 0) ? ST_BODY : ST_HEAD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_HEAD: begin
          if (w_shift && (r_pos == POS_HEAD_LAST)) begin
            w_state_nxt = ST_BODY;
          end else begin
            w_state_nxt = ST_HEAD;
          end
        end
        ST_BODY: begin
          if (w_shift && (r_pos == POS_BODY_LAST)) begin
            w_state_nxt = ST_TAIL;
          end else begin
            w_state_nxt = ST_BODY;
          end
        end
        ST_TAIL: w_state_nxt = ST_TAIL;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Frame sequencer state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Window shift register, position/phase counters and output handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_window    <= '0;
      r_pos       <= '0;
      r_phase     <= '0;
      r_win_cnt   <= '0;
      r_index     <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_last_acc  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_done;
      if (r_state == ST_IDLE) begin
        if (w_start_ok) begin
          r_pos      <= '0;
          r_phase    <= PH_FIRST;
          r_win_cnt  <= '0;
          r_last_acc <= 1'b0;
        end
      end else begin
        if (w_shift) begin
          r_window <= w_window_nxt;
          r_pos    <= r_pos + PW'(1);
          r_phase  <= (r_phase == {PHW{1'b0}}) ? PH_STRIDE : (r_phase - PHW'(1));
        end
        // A completing shift in the accept cycle keeps out_valid high (S=1 full rate)
        if (w_complete) begin
          r_out_valid <= 1'b1;
          r_index     <= r_win_cnt;
          r_out_last  <= (r_win_cnt == WIN_LAST);
          r_win_cnt   <= r_win_cnt + IW'(1);
        end else if (w_accept) begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
        if (w_accept && r_out_last) begin
          r_last_acc <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_stream_selector.sv
// tb_rf_stream_selector
//   Directed bench for rf_stream_selector: default geometry (T1-T4), a
//   two-channel small frame with trailing positions (T5) and a P=0, S=1
//   full-rate frame (T6). Expected windows come from a padded-frame model and
//   hand-computed constants.
module tb_rf_stream_selector;

  localparam int W_D = 1024;
  localparam int P_D = 28;
  localparam int F_D = 64;
  localparam int S_D = 8;

  int n_tests = 0;
  int n_fail  = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default instance
  logic          d_start, d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_last, d_busy, d_done;
  logic [15:0]   d_in_data;
  logic [0:1023] d_out_window;
  logic [7:0]    d_out_index;

  // T5 instance: C=2 W=10 P=1 F=4 S=3
  logic          a_start, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_busy, a_done;
  logic [31:0]   a_in_data;
  logic [0:127]  a_out_window;
  logic [1:0]    a_out_index;

  // T6 instance: C=1 W=8 P=0 F=4 S=1
  logic          b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy, b_done;
  logic [15:0]   b_in_data;
  logic [0:63]   b_out_window;
  logic [2:0]    b_out_index;

  rf_stream_selector u_dut_d (
    .clk(clk), .reset(rst_n), .start(d_start), .in_data(d_in_data), .in_valid(d_in_valid),
    .in_ready(d_in_ready), .out_window(d_out_window), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_index(d_out_index), .out_last(d_out_last), .busy(d_busy), .done(d_done)
  );

  rf_stream_selector #(.DATA_WIDTH(16), .C(2), .W(10), .P(1), .F(4), .S(3)) u_dut_a (
    .clk(clk), .reset(rst_n), .start(a_start), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_window(a_out_window), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_index(a_out_index), .out_last(a_out_last), .busy(a_busy), .done(a_done)
  );

  rf_stream_selector #(.DATA_WIDTH(16), .C(1), .W(8), .P(0), .F(4), .S(1)) u_dut_b (
    .clk(clk), .reset(rst_n), .start(b_start), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_window(b_out_window), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_index(b_out_index), .out_last(b_out_last), .busy(b_busy), .done(b_done)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compares two right-aligned windows; reports the first differing 64-bit chunk
  task automatic cmp_win(input string tag, input logic [0:1023] obs, input logic [0:1023] exp);
    int sel = 15;
    for (int i = 15; i >= 0; i--) begin
      if (obs[i*64 +: 64] !== exp[i*64 +: 64]) sel = i;
    end
    check_eq($sformatf("%s[%0d]", tag, sel), obs[sel*64 +: 64], exp[sel*64 +: 64]);
  endtask

  // Window k of the padded frame; sample n (1-based) carries n on ch0 and 100+n on ch1
  function automatic logic [0:1023] model_win(input int k, input int cn, input int w,
                                              input int p, input int f, input int s);
    logic [0:1023] e;
    int tb;
    e  = '0;
    tb = f * cn * 16;
    for (int j = 0; j < f; j++) begin
      for (int c = 0; c < cn; c++) begin
        int pos;
        int v;
        pos = k * s + j;
        if (pos < p || pos >= p + w) v = 0;
        else v = pos - p + 1 + ((c == 1) ? 100 : 0);
        e[1024 - tb + (j * cn + c) * 16 +: 16] = 16'(v);
      end
    end
    return e;
  endfunction

  // One default-geometry frame; optional gaps, stall at window stall_k, reset at window reset_k
  task automatic run_default(input string tn, input bit gaps, input int stall_k, input int reset_k);
    int n = 1;
    int cyc = 0;
    int nwin = 0;
    int acc_cyc = -1;
    int stall = 0;
    int bad_head = 0;
    int bad_tail = 0;
    bit fin = 1'b0;
    bit aborted = 1'b0;
    d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    while (!fin && !aborted && cyc < 4000) begin
      d_in_valid  = gaps ? ($urandom_range(0, 9) >= 3) : 1'b1;
      d_in_data   = 16'(n);
      d_out_ready = 1'b1;
      if (stall_k >= 0 && d_out_valid && d_out_index == 8'(stall_k) && stall < 10) d_out_ready = 1'b0;
      #1;
      if (cyc < P_D && d_in_ready) bad_head++;
      if (n > W_D && d_in_ready) bad_tail++;
      if (reset_k >= 0 && d_out_valid && d_out_index == 8'(reset_k)) begin
        rst_n = 1'b0;
        #1;
        check_eq({tn, " rst out_valid"}, d_out_valid, 0);
        check_eq({tn, " rst in_ready"}, d_in_ready, 0);
        check_eq({tn, " rst out_index"}, d_out_index, 0);
        check_eq({tn, " rst out_last"}, d_out_last, 0);
        check_eq({tn, " rst busy"}, d_busy, 0);
        check_eq({tn, " rst done"}, d_done, 0);
        cmp_win({tn, " rst window"}, d_out_window, '0);
        aborted = 1'b1;
      end else begin
        if (!d_out_ready) begin
          check_eq({tn, " stall in_ready"}, d_in_ready, 0);
          check_eq({tn, " stall index"}, d_out_index, 64'(stall_k));
          cmp_win({tn, " stall window"}, d_out_window, model_win(stall_k, 1, W_D, P_D, F_D, S_D));
          stall++;
        end else if (d_out_valid) begin
          check_eq($sformatf("%s index k%0d", tn, nwin), d_out_index, 64'(nwin));
          check_eq($sformatf("%s last k%0d", tn, nwin), d_out_last, 64'(nwin == 127));
          cmp_win($sformatf("%s window k%0d", tn, nwin), d_out_window, model_win(nwin, 1, W_D, P_D, F_D, S_D));
          if (nwin == 0) begin
            check_eq({tn, " k0 s24-27"}, d_out_window[24*16 +: 64], 64'h0);
            check_eq({tn, " k0 s28-31"}, d_out_window[28*16 +: 64], 64'h0001_0002_0003_0004);
          end
          if (nwin == 1) check_eq({tn, " k1 s20-23"}, d_out_window[20*16 +: 64], 64'h0001_0002_0003_0004);
          if (nwin == 127) begin
            check_eq({tn, " k127 s0-3"}, d_out_window[0 +: 64], 64'h03dd_03de_03df_03e0);
            check_eq({tn, " k127 s32-35"}, d_out_window[32*16 +: 64], 64'h03fd_03fe_03ff_0400);
            check_eq({tn, " k127 s36-39"}, d_out_window[36*16 +: 64], 64'h0);
          end
          acc_cyc = cyc;
          nwin++;
        end
        if (d_in_valid && d_in_ready) n++;
        if (d_done) begin
          fin = 1'b1;
          check_eq({tn, " done cycle"}, 64'(cyc), 64'(acc_cyc + 1));
        end else begin
          @(negedge clk);
          cyc++;
        end
      end
    end
    if (aborted) begin
      @(negedge clk);
      rst_n = 1'b1;
      d_in_valid = 1'b0;
      @(negedge clk);
    end else begin
      check_eq({tn, " finished"}, fin, 1);
      check_eq({tn, " windows"}, 64'(nwin), 64'd128);
      check_eq({tn, " samples"}, 64'(n - 1), 64'(W_D));
      check_eq({tn, " in_ready in HEAD"}, 64'(bad_head), 64'd0);
      check_eq({tn, " in_ready in TAIL"}, 64'(bad_tail), 64'd0);
      if (stall_k >= 0) check_eq({tn, " stall cycles"}, 64'(stall), 64'd10);
      // start held during the done pulse must not open a new frame
      d_start = 1'b1;
      @(negedge clk);
      d_start = 1'b0;
      #1;
      check_eq({tn, " done width"}, d_done, 0);
      check_eq({tn, " start at done"}, d_busy, 0);
      @(negedge clk);
    end
  endtask

  task automatic run_t5();
    int n = 1;
    int cyc = 0;
    int nwin = 0;
    int done_cyc = -1;
    bit fin = 1'b0;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    while (!fin && cyc < 200) begin
      a_in_valid  = 1'b1;
      a_in_data   = {16'(100 + n), 16'(n)};
      a_out_ready = 1'b1;
      #1;
      if (a_out_valid) begin
        check_eq($sformatf("T5 index k%0d", nwin), a_out_index, 64'(nwin));
        check_eq($sformatf("T5 last k%0d", nwin), a_out_last, 64'(nwin == 2));
        cmp_win($sformatf("T5 window k%0d", nwin), a_out_window, model_win(nwin, 2, 10, 1, 4, 3));
        if (nwin == 0) begin
          check_eq("T5 k0 hi", a_out_window[0:63], 64'h0000_0000_0001_0065);
          check_eq("T5 k0 lo", a_out_window[64:127], 64'h0002_0066_0003_0067);
        end
        if (nwin == 2) begin
          check_eq("T5 k2 hi", a_out_window[0:63], 64'h0006_006a_0007_006b);
          check_eq("T5 k2 lo", a_out_window[64:127], 64'h0008_006c_0009_006d);
        end
        nwin++;
      end
      if (a_in_valid && a_in_ready) n++;
      if (a_done) begin
        fin = 1'b1;
        done_cyc = cyc;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    a_in_valid = 1'b0;
    check_eq("T5 windows", 64'(nwin), 64'd3);
    check_eq("T5 samples", 64'(n - 1), 64'd10);
    check_eq("T5 done cycle", 64'(done_cyc), 64'd12);
    @(negedge clk);
    check_eq("T5 idle after done", a_busy, 0);
  endtask

  task automatic run_t6();
    int n = 1;
    int cyc = 0;
    int nwin = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    int done_cyc = -1;
    bit fin = 1'b0;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    while (!fin && cyc < 200) begin
      b_in_valid  = 1'b1;
      b_in_data   = 16'(n);
      b_out_ready = 1'b1;
      b_start     = (cyc == 2);
      #1;
      if (b_out_valid) begin
        check_eq($sformatf("T6 index k%0d", nwin), b_out_index, 64'(nwin));
        check_eq($sformatf("T6 last k%0d", nwin), b_out_last, 64'(nwin == 4));
        cmp_win($sformatf("T6 window k%0d", nwin), b_out_window, model_win(nwin, 1, 8, 0, 4, 1));
        if (nwin == 0) check_eq("T6 k0 hand", b_out_window, 64'h0001_0002_0003_0004);
        if (nwin == 4) check_eq("T6 k4 hand", b_out_window, 64'h0005_0006_0007_0008);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        nwin++;
      end
      if (b_in_valid && b_in_ready) n++;
      if (b_done) begin
        fin = 1'b1;
        done_cyc = cyc;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    b_in_valid = 1'b0;
    b_start    = 1'b0;
    check_eq("T6 windows", 64'(nwin), 64'd5);
    check_eq("T6 first valid", 64'(first_cyc), 64'd4);
    check_eq("T6 back-to-back", 64'(last_cyc - first_cyc), 64'd4);
    check_eq("T6 done cycle", 64'(done_cyc), 64'd9);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    d_start = 1'b0; d_in_valid = 1'b0; d_in_data = 16'h0; d_out_ready = 1'b0;
    a_start = 1'b0; a_in_valid = 1'b0; a_in_data = 32'h0; a_out_ready = 1'b0;
    b_start = 1'b0; b_in_valid = 1'b0; b_in_data = 16'h0; b_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset out_valid", d_out_valid, 0);
    check_eq("reset in_ready", d_in_ready, 0);
    check_eq("reset busy", d_busy, 0);
    check_eq("reset done", d_done, 0);
    check_eq("reset out_index", d_out_index, 0);
    check_eq("reset out_last", d_out_last, 0);
    cmp_win("reset window", d_out_window, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_default("T1", 1'b0, -1, -1);
    run_default("T2", 1'b0, 5, -1);
    run_default("T3", 1'b1, -1, -1);
    run_default("T4a", 1'b0, -1, 40);
    check_eq("T4 busy after reset", d_busy, 0);
    run_default("T4b", 1'b0, -1, -1);
    run_t5();
    run_t6();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
